// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM states, default width and counter-width helper
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/fa_bit_cell.sv
// fa_bit_cell: combinational one-bit full adder
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell over WIDTH cycles; SERIAL_ADDER_SUB_EN adds a subtract mode
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_reg, b_ld;
  logic [CW-1:0] cnt;
  logic carry, carry_ld, fa_sum, fa_cout, accept, last;
  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign last      = cnt == CW'(WIDTH - 1);
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign sum       = out_valid ? sum_reg : '0;
  assign cout      = out_valid ? carry : 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld     = sub ? ~b : b;
  assign carry_ld = sub | cin;
`else
  assign b_ld     = b;
  assign carry_ld = cin;
`endif
  fa_bit_cell u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .sum (fa_sum),
    .cout(fa_cout)
  );
  // next-state: accept in IDLE, finish after WIDTH RUN edges, release on consumer ready
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? RUN : IDLE;
      RUN:     nxt = last ? DONE : RUN;
      DONE:    nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // state register plus operand capture and LSB-first shift through the cell
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b_ld;
        carry <= carry_ld;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        sum_reg <= {fa_sum, sum_reg[WIDTH-1:1]};
        carry   <= fa_cout;
        cnt     <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder at WIDTH=8
module tb_serial_adder;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0, sum;
  logic in_ready, out_valid, cout, busy;
`ifdef SERIAL_ADDER_SUB_EN
  logic sub = 1'b0;
`endif
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  serial_adder #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .busy     (busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c,
                    input logic s, input logic [7:0] es, input logic ec);
    a = x;
    b = y;
    cin = c;
`ifdef SERIAL_ADDER_SUB_EN
    sub = s;
`endif
    in_valid = 1'b1;
    chk({tag, " in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    chk({tag, " busy"}, busy, 1);
    repeat (7) @(posedge clk);
    #1;
    chk({tag, " early out_valid"}, out_valid, 0);
    step();
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " sum"}, sum, es);
    chk({tag, " cout"}, cout, ec);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " idle"}, in_ready, 1);
    chk({tag, " sum cleared"}, sum, 0);
    if (s) chk({tag, " sub flag"}, s, s);
  endtask
  initial begin
    step();
    chk("in_ready in reset", in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    chk("reset busy", busy, 0);
    // carry propagation with held result
    a = 8'hFF; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    chk("ff+01 early", out_valid, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("ff+01 held valid", out_valid, 1);
      chk("ff+01 held sum", sum, 8'h00);
      chk("ff+01 held cout", cout, 1);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("ff+01 released", out_valid, 0);
    chk("ff+01 in_ready", in_ready, 1);
    // full-adder truth table on bit 0
    op("tt000", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    op("tt100", 8'h01, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0);
    op("tt010", 8'h00, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0);
    op("tt110", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);
    op("tt001", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);
    op("tt101", 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0);
    op("tt011", 8'h00, 8'h01, 1'b1, 1'b0, 8'h02, 1'b0);
    op("tt111", 8'h01, 8'h01, 1'b1, 1'b0, 8'h03, 1'b0);
    op("mixed", 8'hA5, 8'h5B, 1'b1, 1'b0, 8'h01, 1'b1);
    // busy rejection
    a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
    step();
    a = 8'hAA;
    step();
    chk("busy in_ready", in_ready, 0);
    repeat (5) step();
    in_valid = 1'b0;
    step();
    step();
    chk("busy out_valid", out_valid, 1);
    chk("busy sum", sum, 8'h46);
    chk("busy cout", cout, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("busy released", busy, 0);
    // reset mid-RUN
    a = 8'h80; b = 8'h80; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("abort in_ready", in_ready, 1);
    chk("abort busy", busy, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("abort no out_valid", out_valid, 0);
    end
    op("80+80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);
    // rst wins over in_valid
    rst = 1'b1; in_valid = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst+valid busy", busy, 0);
    step();
    chk("rst+valid stays idle", busy, 0);
    // out_ready held high: DONE lasts one cycle
    out_ready = 1'b1;
    a = 8'h10; b = 8'h20; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    chk("ordy valid", out_valid, 1);
    chk("ordy sum", sum, 8'h31);
    step();
    chk("ordy one cycle", out_valid, 0);
    out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    op("5-7", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
    op("7-5", 8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1);
    op("sub0", 8'h07, 8'h05, 1'b1, 1'b0, 8'h0D, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
